pcie_rb_drain: RTL
==================

// Module: pcie_rb_drain
// PURPOSE
//  Receive side of the PCIe ring-buffer write interface driven by pdu_gen through dma_avlstrm.
//  Owns the flit ring memory and accepts producer flit writes plus PDU commit (update) pulses.
//  Publishes the committed head pointer and almost_full back to the producer.
//  Drains committed PDUs in order as an Avalon-ST packet stream (sop/eop) toward the host-side DMA engine.
// PARAMETERS
//  PDU_AWIDTH    12   ring address width; DEPTH = 2**PDU_AWIDTH flits of 512b
//  AF_SLACK      64   almost_full asserts when free flits < AF_SLACK
//  SIZE_DEPTH    64   depth of the committed-PDU size FIFO (power of 2)
// PORTS
//  clk                   in   1           single clock
//  rst                   in   1           synchronous, active-high reset
//  pcie_rb_wr_data       in   512         flit payload (flit_lite_t)
//  pcie_rb_wr_addr       in   PDU_AWIDTH  absolute ring slot for the flit
//  pcie_rb_wr_en         in   1           write strobe, no backpressure
//  pcie_rb_wr_base_addr  out  PDU_AWIDTH  committed head pointer (next free slot)
//  pcie_rb_almost_full   out  1           producer throttle
//  pcie_rb_update_valid  in   1           commit one PDU of pcie_rb_update_size flits
//  pcie_rb_update_size   in   PDU_AWIDTH  flit count of committed PDU
//  out_data              out  512         drained flit
//  out_valid/out_ready   out/in 1         Avalon-ST handshake; transfer when both high
//  out_sop/out_eop       out  1           first/last flit of PDU (both high for 1-flit PDU)
//  occupancy             out  PDU_AWIDTH+1 committed, undrained flits
//  err_overflow          out  1           sticky: commit exceeded free space or size FIFO full
//  err_zero_size         out  1           sticky: commit with size 0
// BEHAVIOUR
//  - Reset: head=tail=0, size FIFO empty, FSM IDLE, out_valid/sop/eop=0, out_data=0, almost_full=0, errors=0.
//    Reset mid-PDU discards all ring contents and partial output; no flit is presented after rst.
//  - Write: pcie_rb_wr_en -> mem[pcie_rb_wr_addr] <= wr_data the same edge. No range check; producer writes only at or beyond head.
//  - Commit: on update_valid, if size==0 -> set err_zero_size, ignore.
//    If size>free or size FIFO full -> set err_overflow, ignore.
//    Else head <= (head+size) mod DEPTH and push size to FIFO.
//  - free = DEPTH-1-occupancy; occupancy = (head-tail) mod DEPTH, 0..DEPTH-1, one slot always kept empty.
//  - almost_full (registered) = (free < AF_SLACK) | (size FIFO fill >= SIZE_DEPTH-4).
//  - pcie_rb_wr_base_addr = head register; it updates the cycle after the commit.
//  - FSM:
//    IDLE -> LOAD when size FIFO non-empty.
//    LOAD: pop size into remaining, set first=1 -> STREAM.
//    STREAM: issue a RAM read at tail when the skid buffer has room; tail <= tail+1 mod DEPTH; remaining--.
//      When the last flit is issued, go to LOAD if FIFO non-empty, else IDLE.
//  - Read path: 1-cycle registered RAM read into a 2-entry skid buffer that carries {data,sop,eop}.
//    Full throughput, 1 flit/cycle with out_ready=1.
//    Latency: commit at edge N -> out_valid high at N+4 when idle.
//  - Tail advance frees space at issue time. occupancy and almost_full therefore count only undrained, unissued flits.
//  - Simultaneous commit and issue in one cycle: head and tail both update; occupancy = old+size-1.
//  - Wrap: head/tail and a PDU may straddle DEPTH-1 -> 0; flit order is preserved.
//  - out_valid, once high, holds with stable data/sop/eop until accepted (Avalon-ST rule). out_ready low stalls with no loss.
// TESTING
//  - Reset, then write slots 0..3, commit size 4 -> 4 flits out in order, sop on flit 0, eop on flit 3; head=4, occupancy ends 0.
//  - Commit size 1 -> a single beat with sop=eop=1; back-to-back commits 3,2 -> 5 beats, no idle cycle, eop/sop adjacent.
//  - AW=4 (DEPTH=16), head=14: write slots 14,15,0,1; commit 4 -> data order 14,15,0,1; head=2.
//  - AW=4, fill 15 flits with no drain -> almost_full=1 (AF_SLACK=4); commit 1 more -> err_overflow=1, head unchanged.
//  - out_ready toggled 1/0 every cycle on a 16-flit PDU -> all 16 received, none duplicated, data stable while stalled.
//  - Commit size 0 -> err_zero_size=1, no output; assert rst mid-PDU -> out_valid=0 next cycle, head=tail=0.

Source files
------------

// File: rtl/pcie_rb_drain_if.sv
// Producer/consumer bundle around the PCIe flit ring: flit writes, PDU commits, head/almost_full
// feedback and the Avalon-ST drain stream. The producer/sink side is master, the ring owner is slave.
interface pcie_rb_drain_if #(
    parameter int AW = 12
) ();
    logic [511:0]  pcie_rb_wr_data;
    logic [AW-1:0] pcie_rb_wr_addr;
    logic          pcie_rb_wr_en;
    logic [AW-1:0] pcie_rb_wr_base_addr;
    logic          pcie_rb_almost_full;
    logic          pcie_rb_update_valid;
    logic [AW-1:0] pcie_rb_update_size;
    logic [511:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic [AW:0]   occupancy;
    logic          err_overflow;
    logic          err_zero_size;

    modport master (
        output pcie_rb_wr_data, pcie_rb_wr_addr, pcie_rb_wr_en,
        output pcie_rb_update_valid, pcie_rb_update_size, out_ready,
        input  pcie_rb_wr_base_addr, pcie_rb_almost_full,
        input  out_data, out_valid, out_sop, out_eop,
        input  occupancy, err_overflow, err_zero_size
    );

    modport slave (
        input  pcie_rb_wr_data, pcie_rb_wr_addr, pcie_rb_wr_en,
        input  pcie_rb_update_valid, pcie_rb_update_size, out_ready,
        output pcie_rb_wr_base_addr, pcie_rb_almost_full,
        output out_data, out_valid, out_sop, out_eop,
        output occupancy, err_overflow, err_zero_size
    );
endinterface

// File: rtl/pcie_rb_drain.sv
// Flit ring owner: stores producer flits, queues committed PDU sizes, drains PDUs as an Avalon-ST stream.
// Latency commit->out_valid 4 cycles when idle; out_ready low stalls the 2-entry skid and then the ring reader.
module pcie_rb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_pop_dat,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign o_cnt     = r_cnt;
    assign o_pop_dat = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_push_dat;
    end
endmodule

module pcie_rb_drain #(
    parameter int PDU_AWIDTH = 12,
    parameter int AF_SLACK   = 64,
    parameter int SIZE_DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    pcie_rb_drain_if.slave rb
);
    localparam int AW    = PDU_AWIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int SW    = $clog2(SIZE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM
    } state_t;

    typedef struct packed {
        logic [511:0] dat;
        logic         sop;
        logic         eop;
    } beat_t;

    logic [511:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_rem;
    logic          r_first;
    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_fifo_pop;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [AW-1:0] w_fifo_dat;
    logic [SW:0]   w_fifo_cnt;

    logic [AW-1:0] w_occ;
    logic [AW-1:0] w_free;
    logic          w_size_zero;
    logic          w_no_room;
    logic          w_commit;
    logic          w_issue;
    logic          w_last;
    logic          w_room;
    logic          w_out_pop;

    logic [511:0]  r_rd_dat;
    logic          r_rd_sop;
    logic          r_rd_eop;
    logic          r_rd_vld;
    beat_t         r_sk [2];
    logic          r_sk_wp;
    logic          r_sk_rp;
    logic [1:0]    r_sk_cnt;

    logic          r_af;
    logic          r_err_ovf;
    logic          r_err_zero;

    // One slot always stays empty, so DEPTH-1 is the largest occupancy and free is its complement.
    assign w_occ       = r_head - r_tail;
    assign w_free      = {AW{1'b1}} - w_occ;
    assign w_size_zero = (rb.pcie_rb_update_size == '0);
    assign w_no_room   = (rb.pcie_rb_update_size > w_free) || w_fifo_full;
    assign w_commit    = rb.pcie_rb_update_valid && !w_size_zero && !w_no_room;

    pcie_rb_fifo #(
        .W     (AW),
        .DEPTH (SIZE_DEPTH)
    ) u_size_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_commit),
        .i_push_dat (rb.pcie_rb_update_size),
        .i_pop      (w_fifo_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full),
        .o_cnt      (w_fifo_cnt)
    );

    // Issue only if the flit can land in the skid even if nothing is accepted next cycle.
    assign w_out_pop = (r_sk_cnt != 2'd0) && rb.out_ready;
    assign w_room    = (r_sk_cnt == 2'd0)
                    || ((r_sk_cnt == 2'd1) && (!r_rd_vld || w_out_pop))
                    || ((r_sk_cnt == 2'd2) && !r_rd_vld && w_out_pop);
    assign w_last    = (r_rem == AW'(1));

    // The last issue of a PDU pops the next size directly so back-to-back PDUs stream without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_fifo_pop  = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        if (!w_fifo_empty) w_fifo_pop  = 1'b1;
                        else               w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_rem      <= '0;
            r_first    <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_sop   <= 1'b0;
            r_rd_eop   <= 1'b0;
            r_af       <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_commit) r_head <= r_head + rb.pcie_rb_update_size;
            if (w_issue)  r_tail <= r_tail + AW'(1);
            if (w_fifo_pop) begin
                r_rem   <= w_fifo_dat;
                r_first <= 1'b1;
            end else if (w_issue) begin
                r_rem   <= r_rem - AW'(1);
                r_first <= 1'b0;
            end
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_sop <= r_first;
                r_rd_eop <= w_last;
            end
            r_af <= (int'(w_free) < AF_SLACK) || (int'(w_fifo_cnt) >= SIZE_DEPTH - 4);
            if (rb.pcie_rb_update_valid && w_size_zero)               r_err_zero <= 1'b1;
            if (rb.pcie_rb_update_valid && !w_size_zero && w_no_room) r_err_ovf  <= 1'b1;
        end
    end

    // Ring storage and its registered read port; contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (rb.pcie_rb_wr_en) r_mem[rb.pcie_rb_wr_addr] <= rb.pcie_rb_wr_data;
        if (w_issue)          r_rd_dat <= r_mem[r_tail];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sk[0]  <= '0;
            r_sk[1]  <= '0;
            r_sk_wp  <= 1'b0;
            r_sk_rp  <= 1'b0;
            r_sk_cnt <= 2'd0;
        end else begin
            if (r_rd_vld) begin
                r_sk[r_sk_wp] <= '{dat: r_rd_dat, sop: r_rd_sop, eop: r_rd_eop};
                r_sk_wp       <= ~r_sk_wp;
            end
            if (w_out_pop) r_sk_rp <= ~r_sk_rp;
            r_sk_cnt <= r_sk_cnt + {1'b0, r_rd_vld} - {1'b0, w_out_pop};
        end
    end

    assign rb.out_valid            = (r_sk_cnt != 2'd0);
    assign rb.out_data             = r_sk[r_sk_rp].dat;
    assign rb.out_sop              = r_sk[r_sk_rp].sop;
    assign rb.out_eop              = r_sk[r_sk_rp].eop;
    assign rb.pcie_rb_wr_base_addr = r_head;
    assign rb.pcie_rb_almost_full  = r_af;
    assign rb.occupancy            = {1'b0, w_occ};
    assign rb.err_overflow         = r_err_ovf;
    assign rb.err_zero_size        = r_err_zero;
endmodule
